pipe_addsub: RTL

Parametrised, pipelined add/subtract unit: the sequential successor to the 8-bit combinational ripple adder. It splits a WIDTH-bit carry chain into SEG-bit registered segments, accepts one operation per cycle under a valid/ready handshake, and returns sum, carry and signed overflow after a fixed latency. It is the datapath adder for the wider arithmetic blocks that follow in the exp series.

---
 rtl/addsub_pkg.sv | 11 +
 rtl/addseg.sv | 19 +
 rtl/pipe_addsub.sv | 72 +++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and helpers for the pipelined add/subtract unit
package addsub_pkg;
  localparam int MAX_STAGES = 16;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
  function automatic int stages_of(input int width, input int seg);
    return width / seg;
  endfunction
  function automatic logic ovf_of(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction
endpackage

// File: rtl/addseg.sv
// addseg: SEG-bit registered segment adder with carry in/out and advance enable
module addseg
  import addsub_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           c_in,
  output logic [SEG-1:0] s_seg,
  output logic           c_out
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {c_out, s_seg} <= '0;
    else if (en) {c_out, s_seg} <= {1'b0, a_seg} + {1'b0, b_seg} + (SEG+1)'(c_in);
endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined WIDTH-bit add/subtract split into SEG-bit registered carry segments
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = stages_of(WIDTH, SEG);
  if (WIDTH % SEG != 0 || STAGES < 1 || STAGES > MAX_STAGES) begin : g_chk
    $error("pipe_addsub: WIDTH must be a multiple of SEG giving 1..16 stages");
  end
  op_e              op;
  logic             en, am, bm;
  logic [WIDTH-1:0] b_eff;
  assign op       = op_e'(sub);
  assign en       = out_ready || !out_valid;
  assign in_ready = en;
  assign b_eff    = op == OP_SUB ? ~b : b;
  for (genvar k = 0; k < STAGES; k++) begin : g
    localparam int R = WIDTH - k*SEG;
    logic [R-1:0]         ai, bi;
    logic [SEG-1:0]       s;
    logic [(k+1)*SEG-1:0] full;
    logic                 ci, c, v;
    if (k == 0) begin : g_in
      assign ai   = a;
      assign bi   = b_eff;
      assign ci   = op == OP_SUB ? !cin : cin;
      assign full = s;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) v <= 1'b0;
        else if (en) v <= in_valid;
    end else begin : g_sk
      logic [k*SEG-1:0] low;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {ai, bi, low, v} <= '0;
        else if (en) {ai, bi, low, v} <= {g[k-1].ai[R+SEG-1:SEG], g[k-1].bi[R+SEG-1:SEG], g[k-1].full, g[k-1].v};
      assign ci   = g[k-1].c;
      assign full = {s, low};
    end
    addseg #(.SEG(SEG)) u_seg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .a_seg (ai[SEG-1:0]),
      .b_seg (bi[SEG-1:0]),
      .c_in  (ci),
      .s_seg (s),
      .c_out (c)
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {am, bm} <= '0;
    else if (en) {am, bm} <= {g[STAGES-1].ai[SEG-1], g[STAGES-1].bi[SEG-1]};
  assign out_valid   = g[STAGES-1].v;
  assign {cout, sum} = {g[STAGES-1].c, g[STAGES-1].full};
  assign ovf         = ovf_of(am, bm, sum[WIDTH-1]);
endmodule
